// File: rtl/encoder_pulse_gen.sv
// encoder_pulse_gen: synchronise, debounce and decode a quadrature rotary encoder and its push switch into detent and press strobes
module encoder_pulse_gen #(
    parameter int unsigned DEBOUNCE_CYCLES  = 240000,
    parameter int unsigned STEPS_PER_DETENT = 4,
    parameter logic [1:0]  DETENT_AB        = 2'b11,
    parameter int unsigned NUM_MODES        = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enc_a,
    input  logic       enc_b,
    input  logic       enc_sw,
    output logic       L_pulse,
    output logic       R_pulse,
    output logic       sw_pulse,
    output logic [2:0] current_mode
);
    localparam logic [19:0]        CNT_LAST  = 20'(DEBOUNCE_CYCLES - 1);
    localparam logic signed [3:0]  ACC_MAX   = 4'(STEPS_PER_DETENT);
    localparam logic signed [3:0]  ACC_MIN   = -ACC_MAX;
    localparam logic [2:0]         MODE_LAST = 3'(NUM_MODES - 1);

    logic              a_meta_q, a_meta_d, a_sync_q, a_sync_d;
    logic              b_meta_q, b_meta_d, b_sync_q, b_sync_d;
    logic              sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
    logic [19:0]       a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d, sw_cnt_q, sw_cnt_d;
    logic              a_db_q, a_db_d, b_db_q, b_db_d, sw_db_q, sw_db_d;
    logic [1:0]        ab_prev_q, ab_prev_d;
    logic              sw_prev_q, sw_prev_d;
    logic signed [3:0] acc_q, acc_d;
    logic              l_pulse_q, l_pulse_d, r_pulse_q, r_pulse_d, sw_pulse_q, sw_pulse_d;
    logic [2:0]        mode_q, mode_d;
    logic [1:0]        ab_cur, diff;
    logic              legal, at_detent;
    logic signed [3:0] acc_step, acc_sat;

    // Returns {next debounced value, next counter}; the value flips only after
    // DEBOUNCE_CYCLES consecutive disagreeing edges.
    function automatic logic [20:0] debounce(input logic sync, input logic db, input logic [19:0] cnt);
        logic hit;
        hit = (sync != db) && (cnt == CNT_LAST);
        return {hit ? sync : db, (sync == db || hit) ? 20'd0 : cnt + 20'd1};
    endfunction

    // Gray position along the clockwise cycle 00 -> 10 -> 11 -> 01.
    function automatic logic [1:0] pos(input logic [1:0] ab);
        return {ab[0], ab[1] ^ ab[0]};
    endfunction

    // Next-state logic: synchronisers, debouncers, quadrature accumulator and switch counter.
    always_comb begin
        a_meta_d  = enc_a;
        a_sync_d  = a_meta_q;
        b_meta_d  = enc_b;
        b_sync_d  = b_meta_q;
        sw_meta_d = enc_sw;
        sw_sync_d = sw_meta_q;
        {a_db_d, a_cnt_d}   = debounce(a_sync_q, a_db_q, a_cnt_q);
        {b_db_d, b_cnt_d}   = debounce(b_sync_q, b_db_q, b_cnt_q);
        {sw_db_d, sw_cnt_d} = debounce(sw_sync_q, sw_db_q, sw_cnt_q);
        ab_cur    = {a_db_q, b_db_q};
        ab_prev_d = ab_cur;
        diff      = pos(ab_cur) - pos(ab_prev_q);
        legal     = (diff == 2'd1) || (diff == 2'd3);
        acc_step  = (diff == 2'd1) ? acc_q + 4'sd1 : (diff == 2'd3) ? acc_q - 4'sd1 : acc_q;
        acc_sat   = (acc_step > ACC_MAX) ? ACC_MAX : (acc_step < ACC_MIN) ? ACC_MIN : acc_step;
        at_detent = legal && (ab_cur == DETENT_AB);
        acc_d     = !legal ? acc_q : at_detent ? 4'sd0 : acc_sat;
        r_pulse_d = at_detent && (acc_sat == ACC_MAX);
        l_pulse_d = at_detent && (acc_sat == ACC_MIN);
        sw_prev_d  = sw_db_q;
        sw_pulse_d = sw_prev_q && !sw_db_q;
        mode_d     = !sw_pulse_d ? mode_q : (mode_q == MODE_LAST) ? 3'd0 : mode_q + 3'd1;
    end

    // State registers; reset parks the encoder at its detent and the switch released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_meta_q   <= DETENT_AB[1];
            a_sync_q   <= DETENT_AB[1];
            b_meta_q   <= DETENT_AB[0];
            b_sync_q   <= DETENT_AB[0];
            sw_meta_q  <= 1'b1;
            sw_sync_q  <= 1'b1;
            a_cnt_q    <= '0;
            b_cnt_q    <= '0;
            sw_cnt_q   <= '0;
            a_db_q     <= DETENT_AB[1];
            b_db_q     <= DETENT_AB[0];
            sw_db_q    <= 1'b1;
            ab_prev_q  <= DETENT_AB;
            sw_prev_q  <= 1'b1;
            acc_q      <= '0;
            l_pulse_q  <= 1'b0;
            r_pulse_q  <= 1'b0;
            sw_pulse_q <= 1'b0;
            mode_q     <= '0;
        end else begin
            a_meta_q   <= a_meta_d;
            a_sync_q   <= a_sync_d;
            b_meta_q   <= b_meta_d;
            b_sync_q   <= b_sync_d;
            sw_meta_q  <= sw_meta_d;
            sw_sync_q  <= sw_sync_d;
            a_cnt_q    <= a_cnt_d;
            b_cnt_q    <= b_cnt_d;
            sw_cnt_q   <= sw_cnt_d;
            a_db_q     <= a_db_d;
            b_db_q     <= b_db_d;
            sw_db_q    <= sw_db_d;
            ab_prev_q  <= ab_prev_d;
            sw_prev_q  <= sw_prev_d;
            acc_q      <= acc_d;
            l_pulse_q  <= l_pulse_d;
            r_pulse_q  <= r_pulse_d;
            sw_pulse_q <= sw_pulse_d;
            mode_q     <= mode_d;
        end
    end

    assign L_pulse      = l_pulse_q;
    assign R_pulse      = r_pulse_q;
    assign sw_pulse     = sw_pulse_q;
    assign current_mode = mode_q;
endmodule
